button_conditioner: RTL

- Upstream stage for the clock core's `increment` input.
- Takes the raw asynchronous push-button, synchronises and debounces it, then emits clean single-cycle pulses.
- Adds auto-repeat while the button is held, so time-setting fields advance steadily without repeated presses.
- Instantiated at board top between `btn` and the clock core's `increment`; `pressed` is spare for LED status.

---
 rtl/button_conditioner_pkg.sv | 34 +++
 rtl/button_conditioner_sync_2ff.sv | 28 ++
 rtl/button_conditioner.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the push-button conditioner.
//   KILO          : divider from Hz to cycles per millisecond
//   state_e       : conditioner FSM state encoding
//   ms_to_cycles  : milliseconds -> clock cycles at a given clock frequency
//   max3          : largest of three counts, used to size the shared counter
package button_conditioner_pkg;

  localparam int unsigned KILO = 1000;

  typedef enum logic [2:0] {
    StIdle,
    StPressWait,
    StHoldDelay,
    StHoldRepeat,
    StReleaseWait
  } state_e;

  function automatic int unsigned cycles_per_ms(input int unsigned clk_freq);
    return clk_freq / KILO;
  endfunction

  function automatic int unsigned ms_to_cycles(input int unsigned clk_freq,
                                               input int unsigned ms);
    return cycles_per_ms(clk_freq) * ms;
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/button_conditioner_sync_2ff.sv
// 1-bit two-flop synchroniser with synchronous active-high reset.
//   clk   : destination clock
//   reset : synchronous, active-high; clears both flops
//   d     : asynchronous input
//   q     : synchronised output, lags d by two clock edges
module button_conditioner_sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/button_conditioner.sv
// Push-button conditioner: synchronises and debounces a raw button, then emits
// single-cycle press/release pulses plus an increment pulse with auto-repeat.
//   clk           : system clock
//   reset         : synchronous, active-high
//   btn_in        : raw asynchronous button, active-high
//   pressed       : debounced button level
//   press_pulse   : one cycle per accepted press
//   release_pulse : one cycle per accepted release
//   inc_pulse     : one cycle per accepted press and per auto-repeat
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int unsigned CLK_FREQ        = 100_000_000,
  parameter int unsigned DEBOUNCE_MS     = 10,
  parameter int unsigned REPEAT_DELAY_MS = 500,
  parameter int unsigned REPEAT_RATE_MS  = 100
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse,
  output logic inc_pulse
);

  localparam int unsigned Db   = ms_to_cycles(CLK_FREQ, DEBOUNCE_MS);
  localparam int unsigned Dly  = ms_to_cycles(CLK_FREQ, REPEAT_DELAY_MS);
  localparam int unsigned Rpt  = ms_to_cycles(CLK_FREQ, REPEAT_RATE_MS);
  localparam int unsigned CntW = $clog2(max3(Db, Dly, Rpt) + 1);

  localparam logic [CntW-1:0] DbLast  = CntW'(Db - 1);
  localparam logic [CntW-1:0] DlyLast = CntW'(Dly - 1);
  localparam logic [CntW-1:0] RptLast = CntW'(Rpt - 1);

  logic btn_sync;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            pressed_q, pressed_d;
  logic            press_q, press_d;
  logic            release_q, release_d;
  logic            inc_q, inc_d;

  button_conditioner_sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn_in),
    .q     (btn_sync)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      pressed_q <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      inc_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pressed_q <= pressed_d;
      press_q   <= press_d;
      release_q <= release_d;
      inc_q     <= inc_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pressed_d = pressed_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    inc_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (btn_sync) begin
          state_d = StPressWait;
          cnt_d   = '0;
        end
      end
      StPressWait: begin
        if (!btn_sync) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == DbLast) begin
          state_d   = StHoldDelay;
          cnt_d     = '0;
          pressed_d = 1'b1;
          press_d   = 1'b1;
          inc_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StHoldDelay: begin
        if (!btn_sync) begin
          state_d = StReleaseWait;
          cnt_d   = '0;
        end else if (cnt_q == DlyLast) begin
          state_d = StHoldRepeat;
          cnt_d   = '0;
          inc_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StHoldRepeat: begin
        if (!btn_sync) begin
          state_d = StReleaseWait;
          cnt_d   = '0;
        end else if (cnt_q == RptLast) begin
          cnt_d = '0;
          inc_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StReleaseWait: begin
        // A bounce back high is not a new press: restart the repeat delay only.
        if (btn_sync) begin
          state_d = StHoldDelay;
          cnt_d   = '0;
        end else if (cnt_q == DbLast) begin
          state_d   = StIdle;
          cnt_d     = '0;
          pressed_d = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  assign pressed       = pressed_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign inc_pulse     = inc_q;

endmodule
